zpu_io_uart: RTL and testbench
==============================

// Module: zpu_io_uart
// PURPOSE
//  Memory-mapped UART peripheral on the ZPU core's IO bus (accesses with ioBit set).
//  Consumes the core's IO strobes (out_mem_addr/readEnable/writeEnable, mem_write)
//  and returns mem_read/in_mem_busy. It provides a TX FIFO, an 8N1 transmitter, a
//  baud divisor register and an optional receiver.
// PARAMETERS
//  ADDR_W      27    IO address width (core maxaddrbitincio+1)
//  BASE_ADDR   'h0   value of io_addr[ADDR_W-1:4] decoded as this block
//  FIFO_DEPTH  16    TX FIFO entries; power of 2, >=2
//  DIV_W       16    baud divisor width
//  DIV_RESET   434   reset divisor, clk cycles per bit
// PORTS
//  clk          in   1       clock
//  areset       in   1       reset, asynchronous, active-high
//  io_addr      in   ADDR_W  byte address from core, valid while a strobe is high
//  io_read_en   in   1       single-cycle read strobe
//  io_write_en  in   1       single-cycle write strobe
//  io_wdata     in   32      write data
//  io_rdata     out  32      read data, valid in the cycle io_busy falls after a read
//  io_busy      out  1       access not complete; core waits while 1
//  uart_tx      out  1       serial out, idle high
//  uart_rx      in   1       serial in (asynchronous)
//  irq          out  1       tx_empty | rx_valid
// BEHAVIOUR
//  Reset: io_rdata=0, io_busy=0, uart_tx=1, irq=1 (FIFO empty), divisor=DIV_RESET, flags 0.
//  Map (io_addr[3:2]): 0 TXDATA W push [7:0] | 1 RXDATA R {23'b0,valid,data}, pops
//   | 2 STATUS R {28'b0,ovr,rx_valid,tx_empty,tx_full}, read clears ovr | 3 DIV R/W [DIV_W-1:0].
//  Hit = (io_addr[ADDR_W-1:4]==BASE_ADDR). Unmapped/miss: write ignored, read returns 0.
//  Read handshake: strobe cycle T -> io_busy=1 combinationally; io_rdata is registered at T
//   and presented at T+1 with io_busy=0. Fixed 1-cycle latency, including misses.
//  Write handshake: at T, FIFO not full -> push, io_busy=0. FIFO full -> latch addr/data,
//   io_busy=1 from T until the cycle after the push. The push occurs in the first cycle
//   a slot frees. The strobe is not repeated by the core.
//   DIV/miss writes never busy.
//  Strobes while io_busy=1 are ignored. read_en and write_en together: write wins.
//  TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE or START if FIFO
//   non-empty. Each bit is div cycles. The divisor is latched at START.
//   Divisor <2 is used as 2.
//  FIFO: pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. A push and a pop
//   in the same cycle are both allowed (count unchanged), full or not.
//  tx_empty=1 only when the FIFO is empty and the TX FSM is IDLE.
//  Async reset mid-frame: uart_tx=1 immediately; FIFO contents are discarded.
// CONFIGURATION
//  ZPU_UART_RX_EN defined: receiver present.
//   - uart_rx passes a 2-FF synchroniser; a falling edge starts reception.
//   - Start bit is re-checked at div/2; low -> sample 8 data bits at mid-bit, then STOP.
//   - STOP=1 -> byte loaded into the holding register, rx_valid=1.
//   - STOP=0 -> byte dropped (framing error), receiver back to idle.
//   - New byte while rx_valid=1 -> ovr=1, old byte kept.
//   - RXDATA read clears rx_valid; if a new byte lands in the same cycle, it is loaded and
//     rx_valid stays 1.
//  ZPU_UART_RX_EN undefined: no receiver logic; uart_rx ignored; RXDATA reads 0;
//   rx_valid=ovr=0.
// TESTING
//  1 Reset, read STATUS -> busy 1 cycle, io_rdata=32'h2; read DIV -> 434.
//  2 DIV=4, write TXDATA 8'hA5 -> uart_tx: 0,1,0,1,0,0,1,0,1,1, 4 clk each; then tx_empty=1.
//  3 FIFO_DEPTH=4: 6 back-to-back writes -> 5th holds io_busy high until the first byte
//    leaves the FIFO; all 6 bytes are sent in order with no gaps.
//  4 Read unmapped BASE+1 -> io_rdata=0, busy exactly 1 cycle; write there -> no effect.
//  5 RX_EN: loop uart_tx->uart_rx, send 8'h3C twice, no read -> RXDATA=32'h13C, ovr=1;
//    STATUS read -> ovr cleared.
//  6 Assert areset mid-byte -> uart_tx=1 same cycle; after release FIFO is empty and DIV=434.

Source files
------------

// File: rtl/zpu_io_uart.sv
// rtl/zpu_io_uart.sv - memory-mapped 8N1 UART on the ZPU IO bus with TX FIFO and baud divisor
// Define ZPU_UART_RX_EN to build the receiver and RX holding register.
module zpu_io_uart #(
  parameter int                ADDR_W     = 27,
  parameter logic [ADDR_W-5:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 16,
  parameter int                DIV_W      = 16,
  parameter int                DIV_RESET  = 434
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic              io_read_en,
  input  logic              io_write_en,
  input  logic [31:0]       io_wdata,
  output logic [31:0]       io_rdata,
  output logic              io_busy,
  output logic              uart_tx,
  input  logic              uart_rx,
  output logic              irq
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [31:0]      rdata_q, rdata_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             wr_pend_q, wr_pend_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  tx_state_t        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_div_q, tx_div_d, tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;

  logic             hit, wr_acc, rd_acc, tx_wr, push, pop;
  logic             fifo_full, fifo_empty, tx_empty, rx_pop, ovr_clr;
  logic [AW:0]      fifo_cnt;
  logic [7:0]       push_data;
  logic [DIV_W-1:0] div_eff;
  logic             rx_valid, ovr;
  logic [7:0]       rx_data;

  // A pending TXDATA write blocks every new strobe until it lands in the FIFO.
  assign hit        = (io_addr[ADDR_W-1:4] == BASE_ADDR);
  assign wr_acc     = io_write_en & ~wr_pend_q;
  assign rd_acc     = io_read_en & ~io_write_en & ~wr_pend_q;
  assign tx_wr      = wr_acc & hit & (io_addr[3:2] == 2'd0);
  assign rx_pop     = rd_acc & hit & (io_addr[3:2] == 2'd1);
  assign ovr_clr    = rd_acc & hit & (io_addr[3:2] == 2'd2);
  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = fifo_cnt[AW];
  assign push       = (tx_wr & ~fifo_full) | (wr_pend_q & (~fifo_full | pop));
  assign push_data  = wr_pend_q ? pend_data_q : io_wdata[7:0];
  assign div_eff    = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
  assign tx_empty   = fifo_empty & (tx_state_q == TX_IDLE);
  assign io_busy    = rd_acc | wr_pend_q | (tx_wr & fifo_full);
  assign io_rdata   = rdata_q;
  assign irq        = tx_empty | rx_valid;

  always_comb begin
    div_d       = div_q;
    wr_pend_d   = wr_pend_q;
    pend_data_d = pend_data_q;
    rdata_d     = rdata_q;
    wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
    if (wr_acc && hit && io_addr[3:2] == 2'd3) div_d = io_wdata[DIV_W-1:0];
    if (tx_wr && fifo_full) begin
      wr_pend_d   = 1'b1;
      pend_data_d = io_wdata[7:0];
    end else if (wr_pend_q && push) begin
      wr_pend_d = 1'b0;
    end
    if (rd_acc) begin
      rdata_d = '0;
      if (hit) begin
        case (io_addr[3:2])
          2'd1:    rdata_d = {23'b0, rx_valid, rx_data};
          2'd2:    rdata_d = {28'b0, ovr, rx_valid, tx_empty, fifo_full};
          2'd3:    rdata_d = 32'(div_q);
          default: rdata_d = '0;
        endcase
      end
    end
  end

  // The head byte stays in the FIFO for the whole frame and is popped at the end of STOP.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_div_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    pop        = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          tx_state_d = TX_START;
          tx_div_d   = div_eff;
          tx_cnt_d   = div_eff - DIV_W'(1);
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_shift_d = mem_q[rd_ptr_q[AW-1:0]];
          tx_bit_d   = '0;
          tx_cnt_d   = tx_div_q - DIV_W'(1);
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_cnt_d   = tx_div_q - DIV_W'(1);
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else tx_bit_d = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end
      end
      default: begin
        if (tx_cnt_q == '0) begin
          pop = 1'b1;
          if (fifo_cnt > (AW+1)'(1)) begin
            tx_state_d = TX_START;
            tx_div_d   = div_eff;
            tx_cnt_d   = div_eff - DIV_W'(1);
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    case (tx_state_q)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = tx_shift_q[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rdata_q     <= '0;
      div_q       <= DIV_W'(DIV_RESET);
      wr_pend_q   <= 1'b0;
      pend_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tx_state_q  <= TX_IDLE;
      tx_div_q    <= '0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
    end else begin
      rdata_q     <= rdata_d;
      div_q       <= div_d;
      wr_pend_q   <= wr_pend_d;
      pend_data_q <= pend_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tx_state_q  <= tx_state_d;
      tx_div_q    <= tx_div_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

`ifdef ZPU_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_state_q, rx_state_d;
  logic [2:0]       rx_sync_q, rx_sync_d;
  logic [DIV_W-1:0] rx_div_q, rx_div_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d, ovr_q, ovr_d, rx_done, rx_line;
  logic             unused_bits;

  // rx_sync_q: [0] metastable stage, [1] synchronised line, [2] previous synchronised value.
  assign rx_line     = rx_sync_q[1];
  assign rx_valid    = rx_valid_q;
  assign ovr         = ovr_q;
  assign rx_data     = rx_data_q;
  assign unused_bits = ^{io_wdata, io_addr[1:0]};

  always_comb begin
    rx_sync_d  = {rx_sync_q[1:0], uart_rx};
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_sync_q[2] && !rx_line) begin
          rx_state_d = RX_START;
          rx_div_d   = div_eff;
          rx_cnt_d   = (div_eff >> 1) - DIV_W'(1);
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = rx_line ? RX_IDLE : RX_DATA;
          rx_bit_d   = '0;
          rx_cnt_d   = rx_div_q - DIV_W'(1);
        end else begin
          rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          rx_cnt_d   = rx_div_q - DIV_W'(1);
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
      end
      default: begin
        if (rx_cnt_q == '0) begin
          rx_done    = rx_line;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
      end
    endcase
    rx_valid_d = rx_valid_q & ~rx_pop;
    rx_data_d  = rx_data_q;
    ovr_d      = ovr_q & ~ovr_clr;
    if (rx_done) begin
      if (rx_valid_q && !rx_pop) begin
        ovr_d = 1'b1;
      end else begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rx_state_q <= RX_IDLE;
      rx_sync_q  <= 3'b111;
      rx_div_q   <= '0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_sync_q  <= rx_sync_d;
      rx_div_q   <= rx_div_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
    end
  end
`else
  logic unused_bits;

  assign rx_valid    = 1'b0;
  assign ovr         = 1'b0;
  assign rx_data     = '0;
  assign unused_bits = ^{io_wdata, io_addr[1:0], uart_rx, rx_pop, ovr_clr};
`endif

endmodule

// File: tb/tb_zpu_io_uart.sv
// tb/tb_zpu_io_uart.sv - scoreboard bench for zpu_io_uart: register reads, TX frames, FIFO backpressure, reset
`timescale 1ns/1ps
module tb_zpu_io_uart;
  localparam logic [22:0] BASE = 23'h5;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [26:0] io_addr = '0;
  logic        io_read_en = 1'b0;
  logic        io_write_en = 1'b0;
  logic [31:0] io_wdata = '0;
  logic [31:0] io_rdata;
  logic        io_busy, uart_tx, uart_rx, irq;
  logic        rx_loop = 1'b0;

  assign uart_rx = rx_loop ? uart_tx : 1'b1;
  always #5 clk = ~clk;

  zpu_io_uart #(.ADDR_W(27), .BASE_ADDR(BASE), .FIFO_DEPTH(4), .DIV_W(16), .DIV_RESET(434)) dut (
    .clk(clk), .areset(areset), .io_addr(io_addr), .io_read_en(io_read_en),
    .io_write_en(io_write_en), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_busy(io_busy),
    .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          cur_div = 434;
  logic [31:0] exp_rd_q[$];
  logic [7:0]  exp_tx_q[$];
  int          gap_q[$];
  logic [7:0]  t3_bytes [6];
  int          nb [6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic io_read(input string tag, input logic [22:0] base, input logic [1:0] r,
                         input logic [31:0] exp);
    logic [31:0] e;
    io_addr = {base, r, 2'b00};
    io_read_en = 1'b1;
    exp_rd_q.push_back(exp);
    #1;
    check({tag, "_busy_T"}, io_busy, 1);
    @(posedge clk); #1;
    io_read_en = 1'b0;
    #1;
    check({tag, "_busy_T1"}, io_busy, 0);
    e = exp_rd_q.pop_front();
    check(tag, io_rdata, e);
  endtask

  task automatic io_write(input logic [22:0] base, input logic [1:0] r, input logic [31:0] d,
                          output int nbusy);
    io_addr = {base, r, 2'b00};
    io_wdata = d;
    io_write_en = 1'b1;
    @(posedge clk); #1;
    io_write_en = 1'b0;
    #1;
    nbusy = 0;
    while (io_busy && nbusy < 5000) begin @(posedge clk); #2; nbusy++; end
    check("wr_done", io_busy, 0);
  endtask

  task automatic send(input logic [7:0] b, output int nbusy);
    exp_tx_q.push_back(b);
    io_write(BASE, 2'd0, {24'h0, b}, nbusy);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_tx_q.size() != 0 && n < budget) begin tick(1); n++; end
    check("tx_drain", exp_tx_q.size(), 0);
    tick(2);
  endtask

  // Serial monitor: decodes each frame at cur_div clocks per bit and requires every bit to hold for the full period.
  initial begin : tx_mon
    int d, last_end, gap;
    logic ok, abort, lvl;
    logic [7:0] b, e;
    last_end = 0;
    forever begin
      @(negedge clk);
      if (!areset && uart_tx === 1'b0) begin
        d = cur_div; ok = 1'b1; abort = 1'b0; b = '0;
        gap = cyc - last_end - 1;
        for (int c = 1; c < 10 * d; c++) begin
          @(negedge clk);
          if (areset) begin abort = 1'b1; break; end
          lvl = uart_tx;
          if (c < d) begin
            if (lvl !== 1'b0) ok = 1'b0;
          end else if (c >= 9 * d) begin
            if (lvl !== 1'b1) ok = 1'b0;
          end else if (c % d == 0) begin
            b[c/d-1] = lvl;
          end else if (lvl !== b[c/d-1]) begin
            ok = 1'b0;
          end
        end
        if (!abort) begin
          last_end = cyc;
          gap_q.push_back(gap);
          check("tx_frame_expected", exp_tx_q.size() > 0, 1);
          if (exp_tx_q.size() > 0) begin
            e = exp_tx_q.pop_front();
            check("tx_byte", {23'b0, ok, b}, {23'b0, 1'b1, e});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin : stim
    int n, g, lows;
    t3_bytes[0] = 8'h11; t3_bytes[1] = 8'h22; t3_bytes[2] = 8'h33;
    t3_bytes[3] = 8'h44; t3_bytes[4] = 8'h55; t3_bytes[5] = 8'h66;

    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", io_busy, 0);
    check("rst_tx", uart_tx, 1);
    check("rst_irq", irq, 1);
    check("rst_rdata", io_rdata, 0);
    areset = 1'b0;
    tick(1);

    io_read("status_rst", BASE, 2'd2, 32'h2);
    io_read("div_rst", BASE, 2'd3, 32'd434);

    io_write(BASE, 2'd3, 32'd4, n);
    cur_div = 4;
    io_read("div_4", BASE, 2'd3, 32'd4);
    send(8'hA5, n);
    check("a5_nobusy", n, 0);
    drain(200);
    io_read("status_a5", BASE, 2'd2, 32'h2);
    check("irq_idle", irq, 1);

    io_write(BASE, 2'd3, 32'd1, n);
    io_read("div_1", BASE, 2'd3, 32'd1);
    cur_div = 2;
    send(8'h3C, n);
    drain(200);
    io_write(BASE, 2'd3, 32'd0, n);
    send(8'hC3, n);
    drain(200);

    io_write(BASE, 2'd3, 32'd4, n);
    cur_div = 4;
    gap_q.delete();
    for (int i = 0; i < 6; i++) send(t3_bytes[i], nb[i]);
    for (int i = 0; i < 4; i++) check("fifo_wr_nobusy", nb[i], 0);
    check("w5_busy_long", nb[4] > 8 * 4, 1);
    check("irq_busy", irq, 0);
    io_read("status_full", BASE, 2'd2, 32'h1);
    drain(2000);
    check("gap_count", gap_q.size(), 6);
    if (gap_q.size() > 0) g = gap_q.pop_front();
    while (gap_q.size() > 0) begin
      g = gap_q.pop_front();
      check("frame_gap", g, 0);
    end

    io_read("miss_status", BASE + 23'd1, 2'd2, 32'h0);
    io_read("miss_div", BASE + 23'd1, 2'd3, 32'h0);
    io_write(BASE + 23'd1, 2'd0, 32'h77, n);
    check("miss_tx_nobusy", n, 0);
    io_write(BASE + 23'd1, 2'd3, 32'd9, n);
    check("miss_div_nobusy", n, 0);
    tick(60);
    io_read("div_after_miss", BASE, 2'd3, 32'd4);
    io_read("status_after_miss", BASE, 2'd2, 32'h2);

`ifdef ZPU_UART_RX_EN
    io_write(BASE, 2'd3, 32'd16, n);
    cur_div = 16;
    rx_loop = 1'b1;
    tick(5);
    send(8'h3C, n);
    send(8'h3C, n);
    drain(1000);
    tick(40);
    io_read("status_ovr", BASE, 2'd2, 32'hE);
    io_read("status_ovr_clr", BASE, 2'd2, 32'h6);
    check("irq_rx", irq, 1);
    io_read("rxdata", BASE, 2'd1, 32'h13C);
    io_read("status_rx_pop", BASE, 2'd2, 32'h2);
`else
    rx_loop = 1'b1;
    tick(5);
    send(8'h3C, n);
    drain(200);
    tick(20);
    io_read("rxdata_norx", BASE, 2'd1, 32'h0);
    io_read("status_norx", BASE, 2'd2, 32'h2);
`endif
    rx_loop = 1'b0;

    io_write(BASE, 2'd3, 32'd4, n);
    cur_div = 4;
    io_read("div_pre_rst", BASE, 2'd3, 32'd4);
    send(8'h00, n);
    send(8'h55, n);
    tick(5);
    check("pre_rst_tx", uart_tx, 0);
    #1;
    areset = 1'b1;
    #1;
    check("midframe_rst_tx", uart_tx, 1);
    check("midframe_rst_rdata", io_rdata, 0);
    check("midframe_rst_irq", irq, 1);
    exp_tx_q.delete();
    cur_div = 434;
    tick(2);
    areset = 1'b0;
    tick(1);
    io_read("status_post_rst", BASE, 2'd2, 32'h2);
    io_read("div_post_rst", BASE, 2'd3, 32'd434);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (uart_tx !== 1'b1) lows++;
    end
    check("post_rst_idle", lows, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
